// File: rtl/mesi_cache_ctrl.sv
// mesi_cache_ctrl: per-core MESI coherence controller over a direct-mapped
// tag/state array; drives one snoopy-bus request slot and reacts to snoops.
// Optional MESI_STATS_EN adds saturating hit/miss/snoop-invalidate counters.
module mesi_cache_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned BUS_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              req_read,
  output logic              req_write,
  output logic [ADDR_W-1:0] addr,
  input  logic              snoop_read,
  input  logic              snoop_read_excl,
  input  logic              snoop_invalidate,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              shared_in,
  output logic              shared_out,
  output logic              flush_valid,
  output logic [ADDR_W-1:0] flush_addr
`ifdef MESI_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       snoop_inv_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned CNT_W = $clog2(BUS_LAT + 1);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} fsm_t;

  fsm_t              state_q, state_d;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [1:0]        mesi_q [NUM_LINES];
  logic [ADDR_W-1:0] lat_addr_q;
  logic              lat_we_q;
  logic              resp_hit_q;
  logic              conflict_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [IDX_W-1:0]  req_idx, snp_idx, lat_idx;
  logic [TAG_W-1:0]  req_tag, snp_tag, lat_tag;
  logic              accept, req_hit, req_fast, upgrade;
  logic              snp_hit, snp_kill, snp_upd, snp_flush;
  logic [1:0]        snp_next, inst_state;
  logic              bus_last, conflict_now, conflict_c, victim_flush;

  // Request, snoop and install decode against the pre-update array
  always_comb begin
    req_idx      = cpu_req_addr[IDX_W-1:0];
    req_tag      = cpu_req_addr[ADDR_W-1:IDX_W];
    snp_idx      = snoop_addr[IDX_W-1:0];
    snp_tag      = snoop_addr[ADDR_W-1:IDX_W];
    lat_idx      = lat_addr_q[IDX_W-1:0];
    lat_tag      = lat_addr_q[ADDR_W-1:IDX_W];
    accept       = cpu_req_valid && (state_q == IDLE);
    req_hit      = (mesi_q[req_idx] != ST_I) && (tag_q[req_idx] == req_tag);
    req_fast     = req_hit && !(cpu_req_we && (mesi_q[req_idx] == ST_S));
    snp_hit      = (mesi_q[snp_idx] != ST_I) && (tag_q[snp_idx] == snp_tag);
    snp_kill     = snoop_invalidate || snoop_read_excl;
    snp_upd      = snp_hit && (snp_kill || snoop_read);
    snp_next     = snp_kill ? ST_I : ST_S;
    snp_flush    = snp_upd && (mesi_q[snp_idx] == ST_M);
    shared_out   = snoop_read && snp_hit;
    // A same-cycle snoop on the line wins over the silent E->M upgrade
    upgrade      = accept && cpu_req_we && req_hit && (mesi_q[req_idx] == ST_E)
                   && !(snp_upd && (snp_idx == req_idx));
    bus_last     = (state_q == BUS) && (cnt_q == CNT_W'(BUS_LAT - 1));
    conflict_now = (state_q == BUS) && snp_kill && (snoop_addr == lat_addr_q);
    conflict_c   = conflict_q || conflict_now;
    inst_state   = conflict_c ? ST_I : (lat_we_q ? ST_M : (shared_in ? ST_S : ST_E));
    victim_flush = bus_last && (mesi_q[lat_idx] == ST_M) && (tag_q[lat_idx] != lat_tag);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_fast ? RESP : BUS;
      BUS:     if (bus_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from registered state
  always_comb begin
    cpu_req_ready  = (state_q == IDLE);
    cpu_resp_valid = (state_q == RESP);
    cpu_resp_hit   = (state_q == RESP) && resp_hit_q;
    req_read       = (state_q == BUS) && !lat_we_q;
    req_write      = (state_q == BUS) && lat_we_q;
    addr           = (state_q == BUS) ? lat_addr_q : '0;
  end

  // Request latch, bus timer, line array and flush pulse; install beats snoop
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      resp_hit_q  <= 1'b0;
      conflict_q  <= 1'b0;
      cnt_q       <= '0;
      flush_valid <= 1'b0;
      flush_addr  <= '0;
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        tag_q[i]  <= '0;
        mesi_q[i] <= ST_I;
      end
    end else begin
      if (accept) begin
        lat_addr_q <= cpu_req_addr;
        lat_we_q   <= cpu_req_we;
        resp_hit_q <= req_fast;
        cnt_q      <= '0;
      end
      if (state_q == BUS) cnt_q <= CNT_W'(cnt_q + 1'b1);
      if (state_q == RESP)   conflict_q <= 1'b0;
      else if (conflict_now) conflict_q <= 1'b1;
      // Snoop flush takes the port if both events coincide
      flush_valid <= snp_flush || victim_flush;
      if (snp_flush)         flush_addr <= snoop_addr;
      else if (victim_flush) flush_addr <= {tag_q[lat_idx], lat_idx};
      if (snp_upd) mesi_q[snp_idx] <= snp_next;
      if (upgrade) mesi_q[req_idx] <= ST_M;
      if (bus_last) begin
        tag_q[lat_idx]  <= lat_tag;
        mesi_q[lat_idx] <= inst_state;
      end
    end
  end

`ifdef MESI_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      snoop_inv_cnt <= '0;
    end else begin
      if (state_q == RESP) begin
        if (resp_hit_q) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (snp_hit && snp_kill && (snoop_inv_cnt != 16'hFFFF))
        snoop_inv_cnt <= snoop_inv_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Bench for mesi_cache_ctrl: directed MESI scenarios then random traffic,
// checked cycle by cycle against a transaction-age reference model.
module tb_mesi_cache_ctrl;

  localparam int unsigned AW    = 32;
  localparam int unsigned NL    = 4;
  localparam int unsigned BL    = 2;
  localparam int unsigned IDX_W = $clog2(NL);

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_resp_valid, cpu_resp_hit;
  logic          req_read, req_write;
  logic [AW-1:0] addr;
  logic          snoop_read, snoop_read_excl, snoop_invalidate;
  logic [AW-1:0] snoop_addr;
  logic          shared_in, shared_out;
  logic          flush_valid;
  logic [AW-1:0] flush_addr;
`ifdef MESI_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt, snoop_inv_cnt;
`endif

  always #5 clk = ~clk;

  mesi_cache_ctrl #(.ADDR_W(AW), .NUM_LINES(NL), .BUS_LAT(BL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
    .req_read(req_read), .req_write(req_write), .addr(addr),
    .snoop_read(snoop_read), .snoop_read_excl(snoop_read_excl),
    .snoop_invalidate(snoop_invalidate), .snoop_addr(snoop_addr),
    .shared_in(shared_in), .shared_out(shared_out),
    .flush_valid(flush_valid), .flush_addr(flush_addr)
`ifdef MESI_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .snoop_inv_cnt(snoop_inv_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: line state 0=I 1=S 2=E 3=M, plus the open transaction
  int            ms [NL];
  logic [AW-1:0] mtag [NL];
  bit            m_pend, m_we, m_bus, m_hit, m_conf;
  int            m_age;
  logic [AW-1:0] m_addr;
  bit            e_flush;
  logic [AW-1:0] e_faddr;

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a % AW'(NL));
  endfunction

  function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] a);
    return a >> IDX_W;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NL); i++) begin
      ms[i] = 0;
      mtag[i] = '0;
    end
    m_pend = 0; m_we = 0; m_bus = 0; m_hit = 0; m_conf = 0; m_age = 0;
    m_addr = '0; e_flush = 0; e_faddr = '0;
  endtask

  function automatic bit snoop_hits();
    int si = idx_of(snoop_addr);
    return (ms[si] != 0) && (mtag[si] == tag_of(snoop_addr));
  endfunction

  // Advance the model over one clock edge using the inputs currently applied
  task automatic model_step();
    int            pre [NL];
    logic [AW-1:0] ptag [NL];
    bit            kill, shit, upd, sflush, vflush;
    int            sidx, ridx, li;
    logic [AW-1:0] vaddr;
    pre = ms; ptag = mtag;
    kill = snoop_invalidate || snoop_read_excl;
    sidx = idx_of(snoop_addr);
    shit = (pre[sidx] != 0) && (ptag[sidx] == tag_of(snoop_addr));
    upd = shit && (kill || snoop_read);
    sflush = upd && (pre[sidx] == 3);
    vflush = 0; vaddr = '0;
    if (upd) ms[sidx] = kill ? 0 : 1;
    if (!m_pend) begin
      if (cpu_req_valid) begin
        bit rhit;
        ridx = idx_of(cpu_req_addr);
        rhit = (pre[ridx] != 0) && (ptag[ridx] == tag_of(cpu_req_addr));
        m_pend = 1; m_age = 1; m_we = cpu_req_we; m_addr = cpu_req_addr; m_conf = 0;
        m_bus = !rhit || (cpu_req_we && pre[ridx] == 1);
        m_hit = !m_bus;
        if (cpu_req_we && rhit && pre[ridx] == 2 && !(upd && sidx == ridx)) ms[ridx] = 3;
      end
    end else begin
      if (m_bus && m_age <= int'(BL) && kill && snoop_addr == m_addr) m_conf = 1;
      if (m_bus && m_age == int'(BL)) begin
        li = idx_of(m_addr);
        if (pre[li] == 3 && ptag[li] != tag_of(m_addr)) begin
          vflush = 1;
          vaddr = (ptag[li] << IDX_W) | AW'(li);
        end
        mtag[li] = tag_of(m_addr);
        ms[li] = m_conf ? 0 : (m_we ? 3 : (shared_in ? 1 : 2));
      end
      if (m_age == (m_bus ? int'(BL) + 1 : 1)) begin
        m_pend = 0; m_conf = 0;
      end else begin
        m_age++;
      end
    end
    e_flush = sflush || vflush;
    if (sflush) e_faddr = snoop_addr;
    else if (vflush) e_faddr = vaddr;
  endtask

  task automatic check_outputs();
    bit inbus, rv;
    inbus = m_pend && m_bus && (m_age <= int'(BL));
    rv = m_pend && (m_age == (m_bus ? int'(BL) + 1 : 1));
    chk("cpu_req_ready",  32'(cpu_req_ready),  32'(!m_pend));
    chk("cpu_resp_valid", 32'(cpu_resp_valid), 32'(rv));
    chk("cpu_resp_hit",   32'(cpu_resp_hit),   32'(rv && m_hit));
    chk("req_read",       32'(req_read),       32'(inbus && !m_we));
    chk("req_write",      32'(req_write),      32'(inbus && m_we));
    chk("addr",           addr,                inbus ? m_addr : 32'h0);
    chk("flush_valid",    32'(flush_valid),    32'(e_flush));
    chk("flush_addr",     flush_addr,          e_faddr);
  endtask

  task automatic cyc(input bit v, input bit we, input logic [AW-1:0] a,
                     input bit sr, input bit sx, input bit si,
                     input logic [AW-1:0] sa, input bit sh);
    cpu_req_valid = v; cpu_req_we = we; cpu_req_addr = a;
    snoop_read = sr; snoop_read_excl = sx; snoop_invalidate = si;
    snoop_addr = sa; shared_in = sh;
    #1;
    chk("shared_out", 32'(shared_out), 32'(sr && snoop_hits()));
    model_step();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input bit sh);
    cyc(0, 0, '0, 0, 0, 0, '0, sh);
  endtask

  // One request, then idle until the model reports completion (bounded)
  task automatic req(input bit we, input logic [AW-1:0] a, input bit sh);
    int n;
    cyc(1, we, a, 0, 0, 0, '0, sh);
    n = 0;
    while (m_pend && n < 10) begin
      idle(sh);
      n++;
    end
    chk("req_completes", 32'(m_pend), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1;
    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0;
    snoop_read = 0; snoop_read_excl = 0; snoop_invalidate = 0;
    snoop_addr = '0; shared_in = 0;
    @(posedge clk); #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [AW-1:0] ra, sa;
    model_reset();
    @(negedge clk);
    do_reset();

    // Read miss exclusive, then read hit
    req(0, 32'h10, 0);
    req(0, 32'h10, 0);
    // Silent E->M, then snoop read demotes to S with flush
    req(1, 32'h10, 0);
    cyc(0, 0, '0, 1, 0, 0, 32'h10, 0);
    idle(0);
    // Upgrade from S over the bus, then invalidate with flush, then miss
    req(1, 32'h10, 0);
    cyc(0, 0, '0, 0, 0, 1, 32'h10, 0);
    idle(0);
    req(0, 32'h10, 0);
    // Shared install, dirty it, then evict with a same-index miss
    req(0, 32'h20, 1);
    req(1, 32'h20, 0);
    req(0, 32'h24, 0);
    // Read-exclusive snoop during the bus phase forces an I install
    cyc(1, 0, 32'h30, 0, 0, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 0, 32'h30, 0);
    idle(0);
    idle(0);
    req(0, 32'h30, 0);
    // Reset in the middle of a bus read aborts it and clears the array
    cyc(1, 0, 32'h15, 0, 0, 0, '0, 0);
    idle(0);
    do_reset();
    idle(0);
    req(0, 32'h30, 0);

    // Random traffic over a small address pool so lines collide often
    for (int k = 0; k < 1500; k++) begin
      ra = AW'($urandom_range(0, 15));
      sa = AW'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), ra,
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, sa, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
